// File: rtl/oled_spi_rx_if.sv
// Pipelined wishbone bus bundle for the OLED serial-link receiver.
// The slave modport is the receiver side; the master modport is the CPU/DMA side.
interface oled_spi_rx_if;
    logic        i_wb_cyc;
    logic        i_wb_stb;
    logic        i_wb_we;
    logic [1:0]  i_wb_addr;
    logic [31:0] i_wb_data;
    logic        o_wb_ack;
    logic        o_wb_stall;
    logic [31:0] o_wb_data;

    modport slave (
        input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
        output o_wb_ack, o_wb_stall, o_wb_data
    );

    modport master (
        output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
        input  o_wb_ack, o_wb_stall, o_wb_data
    );
endinterface

// File: rtl/oled_spi_rx.sv
// Write-only OLED serial-link receiver: deserialises {dbit, byte} into a FIFO drained over wishbone.
// Optional push counters on register 2 are enabled by defining OLED_SPI_RX_BYTECOUNT_EN.
module oled_spi_rx #(
    parameter int LGFIFO      = 5,
    parameter int IDLE_CYCLES = 64
) (
    input  logic         i_clk,
    input  logic         i_reset,
    oled_spi_rx_if.slave wb,
    input  logic         i_sck,
    input  logic         i_mosi,
    input  logic         i_dbit,
    output logic         o_int
);
    localparam int DEPTH = 1 << LGFIFO;
    localparam int IW    = $clog2(IDLE_CYCLES);
    localparam logic [IW-1:0]   IDLE_MAX  = IW'(IDLE_CYCLES - 1);
    localparam logic [IW-1:0]   IDLE_PRE  = IW'(IDLE_CYCLES - 2);
    localparam logic [LGFIFO:0] FULL_FILL = (LGFIFO + 1)'(DEPTH);

    logic sck_s1, sck_s2, sck_prev;
    logic mosi_s1, mosi_s2;
    logic dbit_s1, dbit_s2;
    logic rise;

    logic [6:0]    sreg;
    logic [2:0]    bitcnt;
    logic [IW-1:0] idle_cnt;
    logic          idle_hit;
    logic          push_req;
    logic [8:0]    push_word;

    logic [8:0]    mem [DEPTH];
    logic [LGFIFO:0] wr_ptr, rd_ptr, fill;
    logic          empty, full, push_ok, pop, flush;
    logic          overflow, frame_err;

    logic          req, rd_req, wr_req;
    logic [31:0]   read_word;
    logic          unused_bits;

    // SCK resets to its idle-high level so leaving reset never fakes a rising edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sck_s1   <= 1'b1;
            sck_s2   <= 1'b1;
            sck_prev <= 1'b1;
            mosi_s1  <= 1'b0;
            mosi_s2  <= 1'b0;
            dbit_s1  <= 1'b0;
            dbit_s2  <= 1'b0;
        end else begin
            sck_s1   <= i_sck;
            sck_s2   <= sck_s1;
            sck_prev <= sck_s2;
            mosi_s1  <= i_mosi;
            mosi_s2  <= mosi_s1;
            dbit_s1  <= i_dbit;
            dbit_s2  <= dbit_s1;
        end
    end

    assign rise      = sck_s2 && !sck_prev;
    assign push_req  = rise && (bitcnt == 3'd7);
    assign push_word = {dbit_s2, sreg, mosi_s2};
    assign idle_hit  = sck_s2 && !rise && (idle_cnt == IDLE_PRE);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sreg   <= '0;
            bitcnt <= '0;
        end else if (rise) begin
            sreg   <= {sreg[5:0], mosi_s2};
            bitcnt <= bitcnt + 3'd1;
        end else if (idle_hit) begin
            bitcnt <= '0;
        end
    end

    // Saturates at IDLE_CYCLES-1 so a long idle period triggers resync only once.
    always_ff @(posedge i_clk) begin
        if (i_reset || rise || !sck_s2)
            idle_cnt <= '0;
        else if (idle_cnt != IDLE_MAX)
            idle_cnt <= idle_cnt + 1'b1;
    end

    assign req    = wb.i_wb_cyc && wb.i_wb_stb;
    assign rd_req = req && !wb.i_wb_we;
    assign wr_req = req && wb.i_wb_we;

    assign fill    = wr_ptr - rd_ptr;
    assign empty   = (fill == '0);
    assign full    = (fill == FULL_FILL);
    assign pop     = rd_req && (wb.i_wb_addr == 2'd1) && !empty;
    assign flush   = wr_req && (wb.i_wb_addr == 2'd0) && wb.i_wb_data[31];
    assign push_ok = push_req && (!full || pop);

    always_ff @(posedge i_clk) begin
        if (push_ok)
            mem[wr_ptr[LGFIFO-1:0]] <= push_word;
    end

    // Flushing moves rd to the pre-push wr, so a byte landing on the same clock survives.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (flush)
                rd_ptr <= wr_ptr;
            else if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (wr_req && wb.i_wb_addr == 2'd0 && wb.i_wb_data[18])
                overflow <= 1'b0;
            if (push_req && full && !pop)
                overflow <= 1'b1;
            if (wr_req && wb.i_wb_addr == 2'd0 && wb.i_wb_data[19])
                frame_err <= 1'b0;
            if (idle_hit && bitcnt != 3'd0)
                frame_err <= 1'b1;
        end
    end

`ifdef OLED_SPI_RX_BYTECOUNT_EN
    logic [15:0] cmd_count, data_count;
    logic        count_clr;

    assign count_clr = wr_req && (wb.i_wb_addr == 2'd2);

    always_ff @(posedge i_clk) begin
        if (i_reset || count_clr) begin
            cmd_count  <= '0;
            data_count <= '0;
        end else if (push_ok) begin
            if (push_word[8] && data_count != 16'hFFFF)
                data_count <= data_count + 16'd1;
            if (!push_word[8] && cmd_count != 16'hFFFF)
                cmd_count <= cmd_count + 16'd1;
        end
    end
`endif

    always_comb begin
        read_word = '0;
        if (rd_req) begin
            case (wb.i_wb_addr)
                2'd0: read_word = {12'h0, frame_err, overflow, full, empty,
                                   {(16 - LGFIFO - 1){1'b0}}, fill};
                2'd1: if (!empty) read_word = {1'b1, 22'h0, mem[rd_ptr[LGFIFO-1:0]]};
`ifdef OLED_SPI_RX_BYTECOUNT_EN
                2'd2: read_word = {data_count, cmd_count};
`endif
                default: read_word = '0;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wb.o_wb_ack  <= 1'b0;
            wb.o_wb_data <= '0;
            o_int        <= 1'b0;
        end else begin
            wb.o_wb_ack  <= req;
            wb.o_wb_data <= read_word;
            o_int        <= !empty;
        end
    end

    assign wb.o_wb_stall = 1'b0;
    assign unused_bits   = ^{wb.i_wb_data[30:20], wb.i_wb_data[17:0]};
endmodule

// File: tb/tb_oled_spi_rx.sv
// Self-checking bench for oled_spi_rx: table-driven bytes plus hand sequences for
// overflow, frame error, simultaneous pop/push, flush, reset and the optional counters.
module tb_oled_spi_rx;
    logic i_clk = 1'b0;
    logic i_reset, i_sck, i_mosi, i_dbit;
    logic o_int;
    int   checks = 0;
    int   failures = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic        dbit;
        logic [7:0]  data;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[3];

    oled_spi_rx_if wb ();

    oled_spi_rx dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .wb      (wb.slave),
        .i_sck   (i_sck),
        .i_mosi  (i_mosi),
        .i_dbit  (i_dbit),
        .o_int   (o_int)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #3ms;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s: got %08h expected %08h", name, got, want);
        end
    endtask

    task automatic wbRead(input logic [1:0] a, output logic [31:0] d);
        wb.i_wb_cyc  = 1'b1;
        wb.i_wb_stb  = 1'b1;
        wb.i_wb_we   = 1'b0;
        wb.i_wb_addr = a;
        @(negedge i_clk);
        d = wb.o_wb_data;
        checkOutput("read_ack", {31'h0, wb.o_wb_ack}, 32'h1);
        wb.i_wb_cyc = 1'b0;
        wb.i_wb_stb = 1'b0;
    endtask

    task automatic wbWrite(input logic [1:0] a, input logic [31:0] v);
        wb.i_wb_cyc  = 1'b1;
        wb.i_wb_stb  = 1'b1;
        wb.i_wb_we   = 1'b1;
        wb.i_wb_addr = a;
        wb.i_wb_data = v;
        @(negedge i_clk);
        checkOutput("write_ack", {31'h0, wb.o_wb_ack}, 32'h1);
        wb.i_wb_cyc = 1'b0;
        wb.i_wb_stb = 1'b0;
        wb.i_wb_we  = 1'b0;
    endtask

    task automatic sendBit(input logic b);
        i_sck  = 1'b0;
        i_mosi = b;
        repeat (4) @(negedge i_clk);
        i_sck = 1'b1;
        repeat (4) @(negedge i_clk);
    endtask

    task automatic applyStimulus(input logic db, input logic [7:0] v);
        i_dbit = db;
        for (int i = 7; i >= 0; i--) sendBit(v[i]);
    endtask

    task automatic sendExpect(input logic db, input logic [7:0] v);
        applyStimulus(db, v);
        exp_q.push_back({1'b1, 22'h0, db, v});
    endtask

    task automatic readExpect(input string name);
        logic [31:0] d;
        wbRead(2'd1, d);
        if (exp_q.size() == 0) checkOutput({name, "_underrun"}, d, 32'h0);
        else checkOutput(name, d, exp_q.pop_front());
    endtask

    task automatic checkStatus(input string name, input logic [31:0] want);
        logic [31:0] d;
        wbRead(2'd0, d);
        checkOutput(name, d, want);
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  v;

        vecs[0] = '{dbit: 1'b0, data: 8'h15, exp: 32'h80000015};
        vecs[1] = '{dbit: 1'b1, data: 8'h12, exp: 32'h80000112};
        vecs[2] = '{dbit: 1'b1, data: 8'h34, exp: 32'h80000134};

        i_reset = 1'b1; i_sck = 1'b1; i_mosi = 1'b0; i_dbit = 1'b0;
        wb.i_wb_cyc = 1'b0; wb.i_wb_stb = 1'b0; wb.i_wb_we = 1'b0;
        wb.i_wb_addr = 2'd0; wb.i_wb_data = '0;
        repeat (4) @(negedge i_clk);
        i_reset = 1'b0;
        @(negedge i_clk);

        checkOutput("reset_ack", {31'h0, wb.o_wb_ack}, 32'h0);
        checkOutput("reset_data", wb.o_wb_data, 32'h0);
        checkOutput("reset_int", {31'h0, o_int}, 32'h0);
        checkOutput("reset_stall", {31'h0, wb.o_wb_stall}, 32'h0);
        checkStatus("reset_status", 32'h00010000);

        sendExpect(1'b0, 8'hAF);
        checkStatus("single_status", 32'h00000001);
        checkOutput("single_int_high", {31'h0, o_int}, 32'h1);
        readExpect("single_read");
        checkStatus("single_status_after", 32'h00010000);
        checkOutput("single_int_low", {31'h0, o_int}, 32'h0);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(vecs[i].dbit, vecs[i].data);
            exp_q.push_back(vecs[i].exp);
        end
        for (int i = 0; i < 3; i++) readExpect("burst_read");

        for (int i = 0; i < 33; i++) begin
            v = 8'(i);
            if (i < 32) sendExpect(1'b0, v);
            else applyStimulus(1'b0, v);
        end
        checkStatus("ovf_status_full", 32'h00060020);
        for (int i = 0; i < 32; i++) readExpect("ovf_read");
        checkStatus("ovf_status_drained", 32'h00050000);
        wbWrite(2'd0, 32'h00040000);
        checkStatus("ovf_cleared", 32'h00010000);

        i_dbit = 1'b0;
        for (int i = 0; i < 5; i++) sendBit(1'b1);
        repeat (80) @(negedge i_clk);
        checkStatus("frame_err_status", 32'h00090000);
        sendExpect(1'b0, 8'h3C);
        readExpect("frame_resync_read");
        wbWrite(2'd0, 32'h00080000);
        checkStatus("frame_cleared", 32'h00010000);

        for (int i = 0; i < 32; i++) sendExpect(1'b0, 8'(8'h40 + i));
        i_dbit = 1'b1;
        v = 8'hC3;
        for (int i = 7; i >= 1; i--) sendBit(v[i]);
        i_sck = 1'b0;
        i_mosi = v[0];
        repeat (4) @(negedge i_clk);
        i_sck = 1'b1;
        repeat (2) @(negedge i_clk);
        readExpect("popush_read");
        exp_q.push_back(32'h800001C3);
        repeat (2) @(negedge i_clk);
        checkStatus("popush_status", 32'h00020020);
        for (int i = 0; i < 32; i++) readExpect("popush_drain");
        checkStatus("popush_empty", 32'h00010000);

        sendExpect(1'b1, 8'h77);
        wb.i_wb_stb = 1'b1;
        wb.i_wb_addr = 2'd1;
        @(negedge i_clk);
        wb.i_wb_stb = 1'b0;
        checkOutput("nocyc_ack", {31'h0, wb.o_wb_ack}, 32'h0);
        checkStatus("nocyc_status", 32'h00000001);
        readExpect("nocyc_read");

        applyStimulus(1'b0, 8'h11);
        applyStimulus(1'b1, 8'h22);
        wbWrite(2'd0, 32'h80000000);
        checkStatus("flush_status", 32'h00010000);

        wbRead(2'd3, d);
        checkOutput("addr3_read", d, 32'h0);
        wbRead(2'd1, d);
        checkOutput("empty_pop_read", d, 32'h0);

`ifdef OLED_SPI_RX_BYTECOUNT_EN
        wbWrite(2'd2, 32'h0);
        sendExpect(1'b0, 8'hA1);
        sendExpect(1'b1, 8'hB2);
        sendExpect(1'b0, 8'hA3);
        sendExpect(1'b1, 8'hB4);
        sendExpect(1'b1, 8'hB5);
        wbRead(2'd2, d);
        checkOutput("bytecount", d, 32'h00030002);
        wbWrite(2'd2, 32'h0);
        wbRead(2'd2, d);
        checkOutput("bytecount_clear", d, 32'h0);
        for (int i = 0; i < 5; i++) readExpect("bytecount_drain");
`else
        sendExpect(1'b0, 8'hA1);
        wbWrite(2'd2, 32'hFFFFFFFF);
        wbRead(2'd2, d);
        checkOutput("addr2_read", d, 32'h0);
        checkStatus("addr2_write_noeffect", 32'h00000001);
        readExpect("addr2_drain");
`endif

        sendExpect(1'b0, 8'h99);
        for (int i = 7; i >= 5; i--) sendBit(1'b1);
        i_reset = 1'b1;
        repeat (2) @(negedge i_clk);
        i_reset = 1'b0;
        exp_q.delete();
        @(negedge i_clk);
        checkOutput("midreset_int", {31'h0, o_int}, 32'h0);
        checkStatus("midreset_status", 32'h00010000);
        sendExpect(1'b1, 8'h5A);
        readExpect("midreset_read");

        checkOutput("scoreboard_empty", exp_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/oled_spi_rx.md
Name: oled_spi_rx

Overview:
- Device-side receiver for the write-only OLED serial link: SCK, MOSI, and a data/command-bar (dbit) wire, with no chip select and no MISO.
- Deserialises bytes MSB-first and tags each byte with its dbit level.
- Buffers tagged bytes in a FIFO that the CPU or a DMA drains over a 32-bit pipelined wishbone slave.
- Used as an on-chip loopback/capture target for the OLED controller and as a display-model front end in simulation.

Parameters:
- LGFIFO, 5: log2 of FIFO depth; depth is 32 entries of 9 bits ({dbit, byte}).
- IDLE_CYCLES, 64: i_clk cycles with SCK held high and no edge before the bit counter is forced back to a byte boundary.

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  synchronous, active-high reset
- i_wb_cyc  in  1  wishbone cycle
- i_wb_stb  in  1  wishbone strobe
- i_wb_we  in  1  wishbone write enable
- i_wb_addr  in  2  register select
- i_wb_data  in  32  write data
- o_wb_ack  out  1  acknowledge
- o_wb_stall  out  1  stall; tied 0
- o_wb_data  out  32  read data
- i_sck  in  1  serial clock; idles high, async to i_clk
- i_mosi  in  1  serial data
- i_dbit  in  1  1 = display data, 0 = command
- o_int  out  1  level interrupt; high while FIFO non-empty

Behaviour:
- Reset:
  - o_wb_ack=0, o_wb_data=0, o_int=0.
  - FIFO empty; bit counter 0; overflow and frame-error flags 0; idle counter 0.
- Input synchronisation:
  - i_sck, i_mosi and i_dbit each pass through a 2-FF synchroniser.
  - Rising edge = synced SCK 1 with the prior sample 0. Input to edge detect is 3 clocks.
  - SCK must stay stable for at least 2 i_clk cycles per phase. Faster SCK is unsupported.
- Shift, on each rising edge:
  - sreg <= {sreg[6:0], mosi}; bitcnt <= bitcnt+1 (3 bits, wraps 7->0).
  - On the edge where bitcnt==7, push {dbit, sreg[6:0], mosi} on the same clock. dbit is the value sampled at that 8th edge.
- Idle resync:
  - The idle counter counts while synced SCK is high with no edge. It is cleared by any edge or by SCK low.
  - On reaching IDLE_CYCLES-1: if bitcnt!=0, set the frame-error flag and reset bitcnt to 0 (the partial byte is discarded). If bitcnt==0, nothing happens.
  - The counter saturates; it does not re-trigger until an edge occurs.
- FIFO:
  - Circular buffer with LGFIFO+1-bit read/write pointers; fill = wr-rd.
  - Push while full: byte dropped, overflow flag set. Exception: if a pop happens on the same clock, the push is accepted.
  - Push and pop on the same clock with the FIFO non-empty: fill is unchanged.
- Wishbone:
  - o_wb_ack follows i_wb_stb (with i_wb_cyc) by exactly 1 clock; o_wb_data is registered on the same clock.
  - Addr 0 read (status): [15:0] fill (zero-extended), [16] empty, [17] full, [18] overflow, [19] frame error, others 0.
  - Addr 0 write:
    - bit18=1 clears overflow; bit19=1 clears frame error.
    - bit31=1 flushes the FIFO (rd<=wr). A push on the same clock is still kept.
  - Addr 1 read: if non-empty, returns {1'b1 valid in bit31, 22'h0, dbit in bit8, byte in bits 7:0} and pops. If empty, returns 0 and does not pop.
  - Addr 1 writes are ignored.
  - Addr 2: see optional feature.
  - Addr 3: reads 0; writes are ignored.
  - A strobe without i_wb_cyc has no side effect and gets no ack.
- o_int is registered: it equals !empty and is updated 1 clock after a fill change.
- Reset mid-byte: partial byte lost; the FIFO is emptied.

Optional Feature:
- Macro: OLED_SPI_RX_BYTECOUNT_EN.
- When defined:
  - Two 16-bit saturating counters count accepted pushes: the command counter for dbit=0, the data counter for dbit=1.
  - Addr 2 reads {data_count, cmd_count}.
  - Any write to addr 2 clears both counters. Clearing takes priority over a simultaneous increment.
  - Both counters reset to 0.
- When undefined: addr 2 reads 0, no counter logic exists, and writes have no effect.

Test Plan:
- Single command byte: dbit=0, send 0xAF MSB-first. Status reads fill=1 and o_int=1. An addr-1 read returns 0x800000AF, after which status fill=0, empty=1 and o_int drops.
- Mixed burst: command 0x15 followed by data 0x12, 0x34 with dbit=1. Three addr-1 reads return 0x80000015, 0x80000112, 0x80000134 in order.
- Overflow: send 33 bytes 0x00..0x20 without reading. Status shows fill=32, full=1, overflow=1. Reads return 0x00..0x1F; 0x20 is absent. Writing 0x00040000 to addr 0 clears overflow.
- Frame error: send 5 bits then hold SCK high for 64 clocks. Status bit19=1 and the FIFO stays empty. Then send 0x3C: it reads back as 0x8000003C.
- Simultaneous pop and push at full: fill the FIFO to 32, then issue an addr-1 read on the same clock as the 8th edge of a new byte. Fill stays 32 and overflow stays 0.
- With OLED_SPI_RX_BYTECOUNT_EN: 2 command bytes and 3 data bytes give addr 2 = 0x00030002. A write to addr 2 then makes it read 0.
